// File: rtl/alu_seq_muldiv_pkg.sv
// Shared encodings, FSM state type and helpers for the sequential ALU with M-extension.
package alu_seq_muldiv_pkg;

  // Base ops (OP[3]=0)
  localparam logic [2:0] F_ADD  = 3'd0;
  localparam logic [2:0] F_SLL  = 3'd1;
  localparam logic [2:0] F_SLT  = 3'd2;
  localparam logic [2:0] F_SLTU = 3'd3;
  localparam logic [2:0] F_XOR  = 3'd4;
  localparam logic [2:0] F_SR   = 3'd5;
  localparam logic [2:0] F_OR   = 3'd6;
  localparam logic [2:0] F_AND  = 3'd7;

  // M-extension ops (OP[3]=1)
  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_MULHU  = 3'd3;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam logic [2:0] F_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_FIX,
    ST_DONE
  } state_t;

  // Context carried from accept to sign fix-up of a long M op
  typedef struct packed {
    logic [2:0] fn;
    logic       neg;
  } mctx_t;

  function automatic logic [63:0] min_int(input int unsigned xlen);
    return 64'(1) << (xlen - 1);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv_iter.sv
// Radix-2 iterative core: shift-add multiplier or restoring divider on unsigned magnitudes.
// hi:lo holds the 2*XLEN product, or remainder:quotient when dividing.
module alu_seq_muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last_c,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  logic [CW-1:0]   cnt;
  logic            div_mode;
  logic [XLEN-1:0] opb;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, opb};
  end

  // High in the cycle whose edge performs the final iteration
  assign last_c = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      div_mode <= 1'b0;
      opb      <= '0;
      hi       <= '0;
      lo       <= '0;
    end else if (start) begin
      cnt      <= CW'(XLEN);
      div_mode <= is_div;
      opb      <= b;
      hi       <= '0;
      lo       <= a;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      if (div_mode) begin
        if (!diff[XLEN]) begin
          hi <= diff[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b1};
        end else begin
          hi <= shifted[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        hi <= sum[XLEN:1];
        lo <= {sum[0], lo[XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_seq_muldiv.sv
// EX-stage integer ALU: single-cycle RV base ops, iterative MUL/DIV/REM, valid/ready on both sides.
module alu_seq_muldiv
  import alu_seq_muldiv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [3:0]      OP,
  input  logic            ROTATE,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] RESULT,
  output logic            ZERO,
  output logic            SIGN,
  output logic            LTU
);

  localparam int unsigned     SHW     = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = XLEN'(min_int(XLEN));

  state_t            state;
  mctx_t             ctx;
  logic              abort_c, accept_c, start_c;
  logic              is_m_c, is_div_c, div_zero_c, div_ovf_c, fast_c, long_c;
  logic              sgn_a_c, sgn_b_c, neg_a_c, neg_b_c, neg_res_c;
  logic [SHW-1:0]    shamt_c;
  logic [XLEN-1:0]   base_c, quick_c, mag_a_c, mag_b_c, dv_c, fix_c;
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   it_hi, it_lo;
  logic              it_last_c;

  assign abort_c  = RESET | FLUSH;
  assign IN_READY = (state == ST_IDLE) | ((state == ST_DONE) & OUT_READY);
  assign accept_c = IN_VALID & IN_READY;
  assign start_c  = accept_c & long_c & ~abort_c;

  // Base-op datapath
  always_comb begin
    shamt_c = DATA2[SHW-1:0];
    base_c  = '0;
    unique case (OP[2:0])
      F_ADD:  base_c = ROTATE ? (DATA1 - DATA2) : (DATA1 + DATA2);
      F_SLL:  base_c = DATA1 << shamt_c;
      F_SLT:  base_c = XLEN'($signed(DATA1) < $signed(DATA2));
      F_SLTU: base_c = XLEN'(DATA1 < DATA2);
      F_XOR:  base_c = DATA1 ^ DATA2;
      F_SR: begin
        if (ROTATE) base_c = $signed(DATA1) >>> shamt_c;
        else        base_c = DATA1 >> shamt_c;
      end
      F_OR:   base_c = DATA1 | DATA2;
      F_AND:  base_c = DATA1 & DATA2;
    endcase
  end

  // M-op operand conditioning and single-cycle special cases
  always_comb begin
    is_m_c     = OP[3];
    is_div_c   = OP[3] & OP[2];
    sgn_b_c    = (OP[2:0] == F_MUL) || (OP[2:0] == F_MULH) ||
                 (OP[2:0] == F_DIV) || (OP[2:0] == F_REM);
    sgn_a_c    = sgn_b_c || (OP[2:0] == F_MULHSU);
    neg_a_c    = sgn_a_c & DATA1[XLEN-1];
    neg_b_c    = sgn_b_c & DATA2[XLEN-1];
    mag_a_c    = neg_a_c ? -DATA1 : DATA1;
    mag_b_c    = neg_b_c ? -DATA2 : DATA2;
    // Remainder takes the dividend's sign; product/quotient the xor of both
    neg_res_c  = (OP[2] & OP[1]) ? neg_a_c : (neg_a_c ^ neg_b_c);
    div_zero_c = (DATA2 == '0);
    div_ovf_c  = ~OP[0] & (DATA1 == MIN_INT) & (DATA2 == '1);
    fast_c     = is_div_c & (div_zero_c | div_ovf_c);
    long_c     = is_m_c & ENABLE_M & ~fast_c;
    quick_c    = base_c;
    if (is_m_c) begin
      if (!ENABLE_M)       quick_c = '0;
      else if (div_zero_c) quick_c = OP[1] ? DATA1 : '1;
      else                 quick_c = OP[1] ? '0 : MIN_INT;
    end
  end

  // Sign correction and half select once the core has finished
  always_comb begin
    dv_c   = ctx.fn[1] ? it_hi : it_lo;
    prod_c = ctx.neg ? -{it_hi, it_lo} : {it_hi, it_lo};
    if (ctx.fn[2])             fix_c = ctx.neg ? -dv_c : dv_c;
    else if (ctx.fn == F_MUL)  fix_c = prod_c[XLEN-1:0];
    else                       fix_c = prod_c[2*XLEN-1:XLEN];
  end

  alu_seq_muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk    (CLK),
    .rst    (abort_c),
    .start  (start_c),
    .is_div (is_div_c),
    .a      (mag_a_c),
    .b      (mag_b_c),
    .last_c (it_last_c),
    .hi     (it_hi),
    .lo     (it_lo)
  );

  always_ff @(posedge CLK) begin
    if (abort_c) begin
      state     <= ST_IDLE;
      OUT_VALID <= 1'b0;
      RESULT    <= '0;
      ZERO      <= 1'b1;
      SIGN      <= 1'b0;
      LTU       <= 1'b0;
      ctx       <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (accept_c) begin
            LTU <= ~is_m_c & (DATA1 < DATA2);
            if (long_c) begin
              state     <= ST_BUSY;
              OUT_VALID <= 1'b0;
              ctx.fn    <= OP[2:0];
              ctx.neg   <= neg_res_c;
            end else begin
              state     <= ST_DONE;
              OUT_VALID <= 1'b1;
              RESULT    <= quick_c;
              ZERO      <= (quick_c == '0);
              SIGN      <= quick_c[XLEN-1];
            end
          end else if ((state == ST_DONE) && OUT_READY) begin
            state     <= ST_IDLE;
            OUT_VALID <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (it_last_c) state <= ST_FIX;
        end
        ST_FIX: begin
          state     <= ST_DONE;
          OUT_VALID <= 1'b1;
          RESULT    <= fix_c;
          ZERO      <= (fix_c == '0);
          SIGN      <= fix_c[XLEN-1];
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Scoreboard bench for alu_seq_muldiv (XLEN=32): directed vectors, decoupled output monitor.
module tb_alu_seq_muldiv;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, rotate;
  logic        out_valid, out_ready, zero, sign, ltu;
  logic [3:0]  op;
  logic [31:0] data1, data2, result;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        zero;
    logic        sign;
    logic        ltu;
    int          due;
  } exp_t;

  exp_t sb[$];

  alu_seq_muldiv #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .CLK       (clk),
    .RESET     (reset),
    .FLUSH     (flush),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .OP        (op),
    .ROTATE    (rotate),
    .DATA1     (data1),
    .DATA2     (data2),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .RESULT    (result),
    .ZERO      (zero),
    .SIGN      (sign),
    .LTU       (ltu)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops and compares on every output transfer
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && !flush && out_valid === 1'b1 && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got result 0x%0h, expected no transfer", result);
        end else begin
          e = sb.pop_front();
          chk({e.name, ".result"}, 64'(result), 64'(e.res));
          chk({e.name, ".zero"},   64'(zero),   64'(e.zero));
          chk({e.name, ".sign"},   64'(sign),   64'(e.sign));
          chk({e.name, ".ltu"},    64'(ltu),    64'(e.ltu));
          if (e.due >= 0) chk({e.name, ".cycle"}, 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // Present an op until accepted; lat>0 also fixes the expected output cycle
  task automatic issue(input string name, input logic [3:0] o, input logic rot,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] res, input logic ltu_e, input int lat, input bit push);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    rotate   = rot;
    data1    = d1;
    data2    = d2;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
      #1;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s.accept: got in_ready=0 for 200 cycles, expected 1", name);
      in_valid = 1'b0;
    end else if (push) begin
      e.name = name;
      e.res  = res;
      e.zero = (res == 32'd0);
      e.sign = res[31];
      e.ltu  = ltu_e;
      e.due  = (lat > 0) ? cyc + lat : -1;
      sb.push_back(e);
    end
  endtask

  task automatic drop();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("drain.pending", 64'(sb.size()), 64'd0);
  endtask

  task automatic abort_check(input string name, input bit use_flush);
    issue({name, ".divu"}, 4'd13, 1'b0, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0, 0, 1'b0);
    drop();
    repeat (9) @(negedge clk);
    if (use_flush) flush = 1'b1;
    else           reset = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    reset = 1'b0;
    #1;
    chk({name, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({name, ".in_ready"},  64'(in_ready),  64'd1);
    chk({name, ".result"},    64'(result),    64'd0);
    repeat (45) @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    op        = 4'd0;
    rotate    = 1'b0;
    data1     = '0;
    data2     = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.in_ready",  64'(in_ready),  64'd1);
    chk("reset.result",    64'(result),    64'd0);
    chk("reset.zero",      64'(zero),      64'd1);
    chk("reset.ltu",       64'(ltu),       64'd0);
    reset = 1'b0;

    // Base ops, back-to-back
    issue("add",  4'd0, 1'b0, 32'd5,          32'd7,          32'd12,         1'b1, 1, 1'b1);
    issue("sub",  4'd0, 1'b1, 32'd3,          32'd3,          32'd0,          1'b0, 1, 1'b1);
    issue("sra",  4'd5, 1'b1, 32'h8000_0000,  32'h21,         32'hC000_0000,  1'b0, 1, 1'b1);
    issue("srl",  4'd5, 1'b0, 32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0, 1, 1'b1);
    issue("sltu", 4'd3, 1'b0, 32'd1,          32'hFFFF_FFFF,  32'd1,          1'b1, 1, 1'b1);
    issue("slt",  4'd2, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1, 1'b1);
    issue("sll",  4'd1, 1'b0, 32'd1,          32'h3F,         32'h8000_0000,  1'b1, 1, 1'b1);
    issue("xor",  4'd4, 1'b0, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0,  1'b1, 1, 1'b1);
    issue("or",   4'd6, 1'b0, 32'h0F,         32'hF0,         32'hFF,         1'b1, 1, 1'b1);
    issue("and",  4'd7, 1'b1, 32'hFF00,       32'h0FF0,       32'h0F00,       1'b0, 1, 1'b1);
    drop();
    drain();

    // Multiplies, 34-cycle latency
    issue("mulh",   4'd9,  1'b0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 34, 1'b1);
    issue("mulhu",  4'd11, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 1'b0, 34, 1'b1);
    issue("mul",    4'd8,  1'b0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, 34, 1'b1);
    issue("mulhsu", 4'd10, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 34, 1'b1);

    // Divide special cases complete in one cycle
    issue("div_by0",  4'd12, 1'b0, 32'd7,         32'd0,         32'hFFFF_FFFF, 1'b0, 1, 1'b1);
    issue("rem_by0",  4'd14, 1'b0, 32'd7,         32'd0,         32'd7,         1'b0, 1, 1'b1);
    issue("div_ovf",  4'd12, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 1'b1);
    issue("rem_ovf",  4'd14, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 1, 1'b1);
    issue("divu_by0", 4'd13, 1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1, 1'b1);
    issue("remu_by0", 4'd15, 1'b0, 32'd5,         32'd0,         32'd5,         1'b0, 1, 1'b1);

    // Iterative divides
    issue("div_m7_2",  4'd12, 1'b0, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b0, 34, 1'b1);
    issue("rem_m7_2",  4'd14, 1'b0, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 1'b0, 34, 1'b1);
    issue("div_7_m2",  4'd12, 1'b0, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 1'b0, 34, 1'b1);
    issue("rem_7_m2",  4'd14, 1'b0, 32'd7,         32'hFFFF_FFFE,  32'd1,         1'b0, 34, 1'b1);
    issue("divu_100_7",4'd13, 1'b0, 32'd100,       32'd7,          32'd14,        1'b0, 34, 1'b1);
    issue("remu_100_7",4'd15, 1'b0, 32'd100,       32'd7,          32'd2,         1'b0, 34, 1'b1);
    drop();
    drain();

    // Consumer stall: output held, no new accept
    @(negedge clk);
    out_ready = 1'b0;
    issue("stall_sltu", 4'd3, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, 0, 1'b1);
    drop();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall.out_valid", 64'(out_valid), 64'd1);
      chk("stall.result",    64'(result),    64'd1);
      chk("stall.in_ready",  64'(in_ready),  64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("stall.released_once", 64'(out_valid), 64'd0);
    chk("stall.scoreboard",    64'(sb.size()),  64'd0);

    // Abort of an in-flight divide
    abort_check("reset_abort", 1'b0);
    abort_check("flush_abort", 1'b1);

    issue("add_wrap", 4'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, 1'b1);
    drop();
    drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
